// File: rtl/trace_pkg.sv
// Shared types and default widths for the pipeline trace tagger.
//
// Contents:
//   ID_W, CYC_W, STALL_W, FIFO_DEPTH  default widths and buffer depth
//   stage_tag_t                        per-stage tag {v, id, fc, sc[, pc]}
//   trace_rec_t                        retire record {id, fetch/retire cycle, stall_cnt[, pc]}
//
// Optional feature macro: TRACE_PC_EN adds a 16-bit pc field to both structs.
package trace_pkg;

  localparam int ID_W       = 8;
  localparam int CYC_W      = 16;
  localparam int STALL_W    = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic               v;
    logic [ID_W-1:0]    id;
    logic [CYC_W-1:0]   fc;
    logic [STALL_W-1:0] sc;
`ifdef TRACE_PC_EN
    logic [15:0]        pc;
`endif
  } stage_tag_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [CYC_W-1:0]   fetch_cycle;
    logic [CYC_W-1:0]   retire_cycle;
    logic [STALL_W-1:0] stall_cnt;
`ifdef TRACE_PC_EN
    logic [15:0]        pc;
`endif
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Retire-record buffer with a registered head.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full unless popping the same cycle)
//   push_data    record to store
//   pop          remove the head (ignored when empty)
//   full, empty  occupancy flags
//   head         registered copy of the oldest entry; holds its last value when empty
//
// DEPTH must be a power of two, at least 2. Pointers carry one extra MSB so
// full and empty are told apart without a separate counter.
module trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output rec_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  rec_t        mem_q [DEPTH];
  rec_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        head_q, head_d;
  logic        push_en, pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full buffer still accepts.
  assign push_en = push && (!full || pop_en);
  assign head    = head_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Reading from mem_d covers a push straight into an empty buffer.
    if (rd_ptr_d != wr_ptr_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/pipeline_trace_tagger.sv
// Producer side of the pipeline debug trace. Tags each fetched instruction
// with a sequence ID, its fetch cycle and its IF stall count, follows it
// through ID/EX/MEM/WB under the hazard unit's stall/flush, and on retire
// emits one record into a small buffer read by the trace consumer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_valid       IF holds a real instruction this cycle
//   stall             PC and IF/ID freeze; ID/EX takes a bubble (wins over flush)
//   flush             instruction entering IF/ID is killed
//   rec_ready         consumer accepts the record
//   rec_valid, rec_*  record head (id, fetch cycle, retire cycle, stall count)
//   drop_cnt          records lost to a full buffer, saturating at 255
//   ovf               sticky, set on the first drop
//   inflight          number of valid tags in ID/EX/MEM/WB
//
// Handshake: a record transfers on every rising edge where rec_valid and
// rec_ready are both high; rec_valid never depends on rec_ready, and rec_*
// hold steady until the transfer (and keep the last value while empty).
//
// Widths come from trace_pkg. Optional feature macro: TRACE_PC_EN adds
// fetch_pc/rec_pc and carries the PC alongside each tag.
module pipeline_trace_tagger
  import trace_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid,
  input  logic               stall,
  input  logic               flush,
`ifdef TRACE_PC_EN
  input  logic [15:0]        fetch_pc,
  output logic [15:0]        rec_pc,
`endif
  input  logic               rec_ready,
  output logic               rec_valid,
  output logic [ID_W-1:0]    rec_id,
  output logic [CYC_W-1:0]   rec_fetch_cycle,
  output logic [CYC_W-1:0]   rec_retire_cycle,
  output logic [STALL_W-1:0] rec_stall_cnt,
  output logic [7:0]         drop_cnt,
  output logic               ovf,
  output logic [2:0]         inflight
);

  localparam logic [CYC_W-1:0]   CYC_ONE   = 1;
  localparam logic [ID_W-1:0]    ID_ONE    = 1;
  localparam logic [STALL_W-1:0] STALL_ONE = 1;

  stage_tag_t         id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [ID_W-1:0]    next_id_q, next_id_d;
  logic [STALL_W-1:0] stall_acc_q, stall_acc_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;

  trace_rec_t push_rec, head_rec;
  logic       fifo_full, fifo_empty, drop;

  always_comb begin
    cyc_d       = cyc_q + CYC_ONE;
    next_id_d   = next_id_q;
    stall_acc_d = stall_acc_q;
    id_d        = id_q;
    ex_d        = id_q;
    mem_d       = ex_q;
    wb_d        = mem_q;
    if (stall) begin
      ex_d = '0;
      if (fetch_valid && (stall_acc_q != '1)) begin
        stall_acc_d = stall_acc_q + STALL_ONE;
      end
    end else if (flush) begin
      // The killed instruction never consumes an ID.
      id_d        = '0;
      stall_acc_d = '0;
    end else if (fetch_valid) begin
      id_d        = '0;
      id_d.v      = 1'b1;
      id_d.id     = next_id_q;
      // Back-dated to the first cycle the instruction sat in IF.
      id_d.fc     = cyc_q - CYC_W'(stall_acc_q);
      id_d.sc     = stall_acc_q;
`ifdef TRACE_PC_EN
      id_d.pc     = fetch_pc;
`endif
      next_id_d   = next_id_q + ID_ONE;
      stall_acc_d = '0;
    end else begin
      id_d = '0;
    end
  end

  always_comb begin
    push_rec              = '0;
    push_rec.id           = wb_q.id;
    push_rec.fetch_cycle  = wb_q.fc;
    push_rec.retire_cycle = cyc_q;
    push_rec.stall_cnt    = wb_q.sc;
`ifdef TRACE_PC_EN
    push_rec.pc           = wb_q.pc;
`endif
    // Full implies non-empty, so rec_ready alone decides whether a pop frees a slot.
    drop       = wb_q.v && fifo_full && !rec_ready;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    ovf_d = ovf_q || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      next_id_q   <= '0;
      stall_acc_q <= '0;
      id_q        <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      next_id_q   <= next_id_d;
      stall_acc_q <= stall_acc_d;
      id_q        <= id_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wb_q.v),
    .push_data (push_rec),
    .pop       (rec_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_rec)
  );

  assign rec_valid        = !fifo_empty;
  assign rec_id           = head_rec.id;
  assign rec_fetch_cycle  = head_rec.fetch_cycle;
  assign rec_retire_cycle = head_rec.retire_cycle;
  assign rec_stall_cnt    = head_rec.stall_cnt;
`ifdef TRACE_PC_EN
  assign rec_pc           = head_rec.pc;
`endif
  assign drop_cnt         = drop_cnt_q;
  assign ovf              = ovf_q;
  assign inflight         = {2'b00, id_q.v} + {2'b00, ex_q.v} +
                            {2'b00, mem_q.v} + {2'b00, wb_q.v};

endmodule

// File: tb/tb_pipeline_trace_tagger.sv
// Bench for pipeline_trace_tagger: directed scenarios and a randomized run,
// every cycle compared against an instruction-level reference model.
module tb_pipeline_trace_tagger;

  localparam int DEPTH = 4;

  typedef struct {
    int id;
    int fc;
    int rc;
    int sc;
  } mrec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [7:0]  rec_id;
  logic [15:0] rec_fetch_cycle;
  logic [15:0] rec_retire_cycle;
  logic [3:0]  rec_stall_cnt;
  logic [7:0]  drop_cnt;
  logic        ovf;
  logic [2:0]  inflight;
`ifdef TRACE_PC_EN
  logic [15:0] fetch_pc = 16'h0;
  logic [15:0] rec_pc;
`endif

  pipeline_trace_tagger dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .stall            (stall),
    .flush            (flush),
`ifdef TRACE_PC_EN
    .fetch_pc         (fetch_pc),
    .rec_pc           (rec_pc),
`endif
    .rec_ready        (rec_ready),
    .rec_valid        (rec_valid),
    .rec_id           (rec_id),
    .rec_fetch_cycle  (rec_fetch_cycle),
    .rec_retire_cycle (rec_retire_cycle),
    .rec_stall_cnt    (rec_stall_cnt),
    .drop_cnt         (drop_cnt),
    .ovf              (ovf),
    .inflight         (inflight)
  );

  // clock
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: instruction-level view
  int    m_cyc, m_next_id, m_acc, m_drop;
  bit    m_ovf, m_idv;
  mrec_t m_idr;
  mrec_t pend_q[$];   // past ID, waiting for their retire cycle
  mrec_t exp_q[$];    // expected buffer contents, oldest first
  mrec_t m_last;
  mrec_t log_q[$];    // records actually taken from the DUT

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_next_id = 0; m_acc = 0; m_drop = 0;
    m_ovf = 0; m_idv = 0;
    m_idr = '{0, 0, 0, 0};
    m_last = '{0, 0, 0, 0};
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic model_edge(input bit fv, input bit st, input bit fl, input bit rdy);
    mrec_t r;
    bit    have_push;
    have_push = 0;
    r = '{0, 0, 0, 0};
    if (pend_q.size() > 0 && pend_q[0].rc == m_cyc) begin
      r = pend_q.pop_front();
      have_push = 1;
    end
    if (exp_q.size() > 0 && rdy) exp_q.delete(0);
    if (have_push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else begin
        m_drop++;
        m_ovf = 1;
      end
    end
    if (st) begin
      if (fv && m_acc < 15) m_acc++;
    end else begin
      // leaving ID now: EX next cycle, MEM after, WB three cycles on
      if (m_idv) begin
        r = m_idr;
        r.rc = m_cyc + 3;
        pend_q.push_back(r);
      end
      if (fl) begin
        m_idv = 0;
        m_acc = 0;
      end else if (fv) begin
        m_idv = 1;
        m_idr.id = m_next_id;
        m_idr.fc = (m_cyc - m_acc) & 16'hFFFF;
        m_idr.sc = m_acc;
        m_next_id = (m_next_id + 1) & 8'hFF;
        m_acc = 0;
      end else begin
        m_idv = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    mrec_t h;
    if (exp_q.size() > 0) h = exp_q[0];
    else h = m_last;
    m_last = h;
    check("rec_valid", {31'b0, rec_valid}, {31'b0, exp_q.size() > 0});
    check("rec_id", {24'b0, rec_id}, h.id & 8'hFF);
    check("rec_fetch_cycle", {16'b0, rec_fetch_cycle}, h.fc & 16'hFFFF);
    check("rec_retire_cycle", {16'b0, rec_retire_cycle}, h.rc & 16'hFFFF);
    check("rec_stall_cnt", {28'b0, rec_stall_cnt}, h.sc & 4'hF);
    check("drop_cnt", {24'b0, drop_cnt}, (m_drop > 255) ? 255 : m_drop);
    check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    check("inflight", {29'b0, inflight}, m_idv + pend_q.size());
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input bit fv, input bit st, input bit fl, input bit rdy);
    mrec_t r;
    fetch_valid = fv; stall = st; flush = fl; rec_ready = rdy;
    if (rec_valid && rdy) begin
      r.id = rec_id; r.fc = rec_fetch_cycle; r.rc = rec_retire_cycle; r.sc = rec_stall_cnt;
      log_q.push_back(r);
    end
    model_edge(fv, st, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    fetch_valid = 0; stall = 0; flush = 0; rec_ready = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rec_valid", {31'b0, rec_valid}, 0);
    check("rst_rec_id", {24'b0, rec_id}, 0);
    check("rst_rec_fetch_cycle", {16'b0, rec_fetch_cycle}, 0);
    check("rst_rec_retire_cycle", {16'b0, rec_retire_cycle}, 0);
    check("rst_rec_stall_cnt", {28'b0, rec_stall_cnt}, 0);
    check("rst_drop_cnt", {24'b0, drop_cnt}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    check("rst_inflight", {29'b0, inflight}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic check_log(input string tag, input int k, input int id, input int fc,
                           input int rc, input int sc);
    mrec_t r;
    r = '{-1, -1, -1, -1};
    if (k < log_q.size()) r = log_q[k];
    check($sformatf("%s_id", tag), r.id, id);
    check($sformatf("%s_fc", tag), r.fc, fc);
    check($sformatf("%s_rc", tag), r.rc, rc);
    check($sformatf("%s_sc", tag), r.sc, sc);
  endtask

  initial begin
    // 1: continuous fetch, always ready
    do_reset();
    for (int c = 0; c < 16; c++) step(c < 10, 0, 0, 1);
    for (int k = 0; k < 6; k++) check_log($sformatf("t1_rec%0d", k), k, k, k, k + 4, 0);

    // 2: stall in cycles 5-6
    do_reset();
    for (int c = 0; c < 20; c++) step(1, (c == 5) || (c == 6), 0, 1);
    check_log("t2_id4", 4, 4, 4, 10, 0);
    check_log("t2_id5", 5, 5, 5, 11, 2);
    check_log("t2_id6", 6, 6, 8, 12, 0);

    // 3: flush in cycle 6
    do_reset();
    for (int c = 0; c < 16; c++) step(1, 0, c == 6, 1);
    check_log("t3_id5", 5, 5, 5, 9, 0);
    check_log("t3_id6", 6, 6, 7, 11, 0);

    // 4: consumer blocked through six retires, then drained
    do_reset();
    for (int c = 0; c < 12; c++) step(c < 6, 0, 0, 0);
    check("t4_drop_cnt", {24'b0, drop_cnt}, 2);
    check("t4_ovf", {31'b0, ovf}, 1);
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1);
    check("t4_log_size", log_q.size(), 4);
    for (int k = 0; k < 4; k++) check_log($sformatf("t4_rec%0d", k), k, k, k, k + 4, 0);

    // 5: stall and flush together in cycle 3
    do_reset();
    for (int c = 0; c < 14; c++) step(1, c == 3, c == 3, 1);
    check_log("t5_id2", 2, 2, 2, 7, 0);
    check_log("t5_id3", 3, 3, 3, 8, 1);
    check_log("t5_id4", 4, 4, 5, 9, 0);

    // 6: reset with three in flight
    do_reset();
    for (int c = 0; c < 3; c++) step(1, 0, 0, 1);
    check("t6_inflight", {29'b0, inflight}, 3);
    do_reset();
    for (int c = 0; c < 8; c++) step(1, 0, 0, 1);
    check_log("t6_first", 0, 0, 0, 4, 0);

    // stall counter saturation
    do_reset();
    step(1, 0, 0, 1);
    for (int c = 0; c < 20; c++) step(1, 1, 0, 1);
    for (int c = 0; c < 8; c++) step(1, 0, 0, 1);
    check_log("sat_id1", 1, 1, 6, 25, 15);

    // randomized run, long enough to wrap the sequence ID
    do_reset();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60);
    end
    for (int c = 0; c < 12; c++) step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
